branch_seq_ctrl: RTL

//  Branch sequencing controller for the fetch/execute loop. Holds the 4-bit CPSR (N,Z,C,V = bits 3..0),

---
 rtl/branch_seq_ctrl_pkg.sv | 30 +++
 rtl/branch_cond_eval.sv | 30 +++
 rtl/branch_seq_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/branch_seq_ctrl_pkg.sv
// Shared definitions for the branch sequencing controller:
// condition codes, CPSR bit positions and FSM state encoding.
package branch_seq_ctrl_pkg;

  typedef enum logic [3:0] {
    COND_JMP = 4'h0,
    COND_JEQ = 4'h1,
    COND_JNE = 4'h2,
    COND_JGT = 4'h3,
    COND_JGE = 4'h4,
    COND_JLT = 4'h5,
    COND_JLE = 4'h6
  } cond_e;

  localparam int unsigned CPSR_N = 3;
  localparam int unsigned CPSR_Z = 2;
  localparam int unsigned CPSR_C = 1;
  localparam int unsigned CPSR_V = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Signed "less than" from the flags: N differs from V.
  function automatic logic flags_lt(input logic n, input logic v);
    return n ^ v;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational jump-condition resolver: N/Z/V flags + condition code
// -> taken, cond_err (undefined code; never taken).
module branch_cond_eval
  import branch_seq_ctrl_pkg::*;
(
  input  logic       n_i,
  input  logic       z_i,
  input  logic       v_i,
  input  logic [3:0] cond_i,
  output logic       taken_o,
  output logic       cond_err_o
);

  // Decode the condition against the supplied flags.
  always_comb begin
    taken_o    = 1'b0;
    cond_err_o = 1'b0;
    case (cond_i)
      COND_JMP: taken_o = 1'b1;
      COND_JEQ: taken_o = z_i;
      COND_JNE: taken_o = !z_i;
      COND_JGT: taken_o = !z_i && !flags_lt(n_i, v_i);
      COND_JGE: taken_o = !flags_lt(n_i, v_i);
      COND_JLT: taken_o = flags_lt(n_i, v_i);
      COND_JLE: taken_o = z_i || flags_lt(n_i, v_i);
      default:  cond_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Branch sequencing controller: holds the NZCV CPSR, accepts one jump
// request per handshake, redirects the fetch PC on a taken jump and
// flushes younger stages for FLUSH_CYCLES cycles.
// Optional macro FLAG_FWD_EN: bypass flags_in into the condition check
// when the ALU writes flags in the same cycle, instead of stalling.
module branch_seq_ctrl
  import branch_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned PC_STEP      = 1,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              flags_we,
  input  logic [3:0]        flags_in,
  input  logic              br_valid,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_redirect,
  output logic              flush,
  output logic              stall,
  output logic              cond_err,
  output logic [3:0]        cpsr_out
);

  localparam int unsigned       CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(PC_STEP);

  logic [3:0]        cpsr_q;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] pc_q;
  logic              redirect_q;
  logic              flush_q;
  logic              cond_err_q;

  logic [3:0]        eval_flags;
  logic              taken;
  logic              undef_cond;
  logic              accept;

  // Pick the flags the condition sees and whether a request can be taken now.
  always_comb begin
`ifdef FLAG_FWD_EN
    eval_flags = flags_we ? flags_in : cpsr_q;
    br_ready   = (state_q == ST_RUN);
`else
    eval_flags = cpsr_q;
    br_ready   = (state_q == ST_RUN) && !flags_we;
`endif
    accept = br_valid && br_ready;
    stall  = br_valid && !br_ready;
  end

  branch_cond_eval u_cond_eval (
    .n_i        (eval_flags[CPSR_N]),
    .z_i        (eval_flags[CPSR_Z]),
    .v_i        (eval_flags[CPSR_V]),
    .cond_i     (br_cond),
    .taken_o    (taken),
    .cond_err_o (undef_cond)
  );

  // CPSR follows every ALU flag write, whatever the FSM state.
  always_ff @(posedge clk) begin
    if (rst) cpsr_q <= '0;
    else if (flags_we) cpsr_q <= flags_in;
  end

  // RUN/FLUSH sequencer with registered PC, redirect, flush and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      pc_q       <= PC_RST;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      cond_err_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      cond_err_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (accept && taken) begin
            pc_q       <= br_target;
            redirect_q <= 1'b1;
            flush_q    <= 1'b1;
            cnt_q      <= CNT_INIT;
            state_q    <= ST_FLUSH;
          end else if (fetch_en) begin
            pc_q <= pc_q + PC_INC;
          end
          if (accept && undef_cond) cond_err_q <= 1'b1;
        end
        ST_FLUSH: begin
          if (cnt_q == '0) begin
            flush_q <= 1'b0;
            state_q <= ST_RUN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign pc_out      = pc_q;
  assign pc_redirect = redirect_q;
  assign flush       = flush_q;
  assign cond_err    = cond_err_q;
  assign cpsr_out    = cpsr_q;

endmodule
